pipe_mux_stage: RTL and testbench
=================================

// Module: pipe_mux_stage
// PURPOSE
// - Parametrised N:1 WIDTH-bit select stage with a registered output and a valid/ready handshake.
// - Chooses one of NUM_IN operands and registers it into the next pipeline stage.
// - Targets PC-next select, forwarding-operand select and writeback select.
// - A 2-entry skid buffer gives full throughput with a fully registered in_ready.
// - Synchronous flush supports branch/exception squash.
// PARAMETERS
// - WIDTH   32  data width of each input operand and of out_data
// - NUM_IN  4   number of selectable inputs; legal range >=2
// - SEL_W   derived localparam = max(1, $clog2(NUM_IN)); not overridable
// PORTS
// - clk        in   1              rising-edge clock, single domain
// - rst        in   1              synchronous, active-high reset
// - in_data    in   NUM_IN*WIDTH   packed operands; operand k = in_data[k*WIDTH +: WIDTH]
// - in_sel     in   SEL_W          binary select, sampled with the beat
// - in_valid   in   1              upstream beat valid
// - in_ready   out  1              stage can accept; driven from a register only
// - flush      in   1              synchronous squash of all held beats
// - out_data   out  WIDTH          selected operand, registered
// - out_valid  out  1              out_data holds a valid beat
// - out_ready  in   1              downstream accepts
// - sel_err    out  1              sticky out-of-range flag; present only with PIPE_MUX_SELCHK_EN
// BEHAVIOUR
// - Handshake
//   - Accept when in_valid && in_ready; transfer out when out_valid && out_ready.
//   - in_valid may not depend on in_ready.
//   - out_data is stable while out_valid && !out_ready.
// - Latency: 1 cycle. A beat accepted in cycle n appears on out_data/out_valid in cycle n+1.
// - Select
//   - data = operand[in_sel], evaluated at acceptance.
//   - in_sel >= NUM_IN (non-power-of-2 NUM_IN): the selected value is all-zero.
// - States: EMPTY (out empty, skid empty), ONE (out valid, skid empty), FULL (out valid, skid valid).
//   - EMPTY: accept -> ONE.
//   - ONE, accept & !pop -> FULL; new beat goes to the skid register.
//   - ONE, accept & pop -> ONE; new beat goes to the output register.
//   - ONE, pop only -> EMPTY.
//   - FULL: pop -> ONE; the skid beat moves to the output register.
//   - FULL: no accept is possible because in_ready = 0.
// - in_ready = register, 1 in EMPTY/ONE, 0 in FULL. Sustained 1 beat/cycle when out_ready is high.
// - Ordering: beats leave in acceptance order; none are dropped or duplicated except on flush.
// - Flush
//   - Next state EMPTY, out_valid = 0, in_ready = 1.
//   - Flush wins over a same-cycle accept; that beat is discarded.
//   - Flush wins over a same-cycle pop; downstream still sees the transfer in that cycle.
// - Reset (also mid-operation): state EMPTY, out_valid 0, out_data 0, in_ready 1, skid contents 0, sel_err 0.
//   - Reset has priority over flush and all handshakes.
// CONFIGURATION
// - `PIPE_MUX_SELCHK_EN defined
//   - Adds the sel_err port.
//   - sel_err is set the cycle after an accepted beat with in_sel >= NUM_IN.
//   - Holds until rst; flush does not clear it. The beat still passes with zero data.
// - Undefined: no sel_err port and no check logic; out-of-range select still yields zero data.
// STRUCTURE
// - pipe_mux_pkg holds:
//   - state typedef {EMPTY, ONE, FULL} with 2-bit encoding;
//   - default WIDTH/NUM_IN constants;
//   - a sel-width function max(1, clog2(n)).
// - One sub-module, mux_n: combinational NUM_IN:1 WIDTH-bit selector with zero for out-of-range select.
// - pipe_mux_stage holds the FSM, the output register and the skid register.
// TESTING
// - Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1; no beat captured.
// - Select sweep, NUM_IN=4, out_ready=1:
//   - operands A0..A3 = 0x11111111..0x44444444, sel 0..3 back-to-back;
//   - out_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles, starting 1 cycle later.
// - Backpressure:
//   - out_ready=0, push 2 beats -> in_ready=0 after the second beat (FULL);
//   - raise out_ready -> beats drain in order, in_ready=1 the cycle after the first pop.
// - Flush in FULL with same-cycle in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped beat never appears.
// - NUM_IN=3, sel=3:
//   - out_data=0;
//   - with `PIPE_MUX_SELCHK_EN, sel_err=1 and it survives a flush;
//   - rst clears sel_err.
// - Random: 10k cycles of random in_valid/out_ready/flush -> scoreboard ordering/data match; no loss outside flush.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared types and constants for the registered N:1 select stage.
// Build option PIPE_MUX_SELCHK_EN adds the sticky sel_err output to pipe_mux_stage.
package pipe_mux_pkg;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_NUM_IN = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pipe_mux_mux_n.sv
// Combinational NUM_IN:1 WIDTH-bit selector; an out-of-range select yields all-zero.
module mux_n
   import pipe_mux_pkg::*;
#(
   parameter  int unsigned WIDTH  = DEF_WIDTH,
   parameter  int unsigned NUM_IN = DEF_NUM_IN,
   localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] i_data,
   input  logic [SEL_W-1:0]        i_sel,
   output logic [WIDTH-1:0]        o_data
);

   always_comb begin
      o_data = '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (32'(i_sel) == k) begin
            o_data = i_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/pipe_mux_stage.sv
// Registered N:1 select stage with valid/ready handshake and a 2-entry skid buffer.
// Build option PIPE_MUX_SELCHK_EN adds the sticky out-of-range select flag sel_err.
module pipe_mux_stage
   import pipe_mux_pkg::*;
#(
   parameter  int unsigned WIDTH  = DEF_WIDTH,
   parameter  int unsigned NUM_IN = DEF_NUM_IN,
   localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef PIPE_MUX_SELCHK_EN
   ,
   output logic                    sel_err
`endif
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_data;
   logic [WIDTH-1:0]   r_skid_data;
   logic [WIDTH-1:0]   w_sel_data;
   logic               w_acc;
   logic               w_pop;
   logic               w_ld_out_in;
   logic               w_ld_out_skid;
   logic               w_ld_skid;

   mux_n #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) u_mux (
      .i_data (in_data),
      .i_sel  (in_sel),
      .o_data (w_sel_data)
   );

   assign w_acc = in_valid & r_in_ready;
   assign w_pop = r_out_valid & out_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_ld_out_in   = 1'b0;
      w_ld_out_skid = 1'b0;
      w_ld_skid     = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_acc) begin
               w_state_nxt = ONE;
               w_ld_out_in = 1'b1;
            end
         end
         ONE: begin
            if (w_acc && !w_pop) begin
               w_state_nxt = FULL;
               w_ld_skid   = 1'b1;
            end else if (w_acc) begin
               w_ld_out_in = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_pop) begin
               w_state_nxt   = ONE;
               w_ld_out_skid = 1'b1;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
      // Squash overrides any same-cycle accept; a same-cycle pop has already transferred.
      if (flush) begin
         w_state_nxt   = EMPTY;
         w_ld_out_in   = 1'b0;
         w_ld_out_skid = 1'b0;
         w_ld_skid     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != FULL);
         r_out_valid <= (w_state_nxt != EMPTY);
         if (w_ld_out_in) begin
            r_out_data <= w_sel_data;
         end else if (w_ld_out_skid) begin
            r_out_data <= r_skid_data;
         end
         if (w_ld_skid) begin
            r_skid_data <= w_sel_data;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

`ifdef PIPE_MUX_SELCHK_EN
   logic r_sel_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel_err <= 1'b0;
      end else if (w_acc && (32'(in_sel) >= NUM_IN)) begin
         r_sel_err <= 1'b1;
      end
   end

   assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Directed and random checks of pipe_mux_stage (NUM_IN=4 and NUM_IN=3 instances).
// Expected beats are queued on acceptance and compared on each downstream transfer.
module tb_pipe_mux_stage;

   logic         clk = 1'b0;
   logic         rst;

   logic [31:0]  ops [4];
   logic [127:0] in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;

   logic [31:0]  ops3 [3];
   logic [95:0]  in_data3;
   logic [1:0]   in_sel3;
   logic         in_valid3;
   logic         in_ready3;
   logic         flush3;
   logic [31:0]  out_data3;
   logic         out_valid3;
   logic         out_ready3;
`ifdef PIPE_MUX_SELCHK_EN
   logic         sel_err;
   logic         sel_err3;
`endif

   int           n_checks = 0;
   int           n_errors = 0;
   logic [31:0]  q [$];

   always #5 clk = ~clk;

   assign in_data  = {ops[3], ops[2], ops[1], ops[0]};
   assign in_data3 = {ops3[2], ops3[1], ops3[0]};

   pipe_mux_stage #(
      .WIDTH  (32),
      .NUM_IN (4)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef PIPE_MUX_SELCHK_EN
      ,
      .sel_err   (sel_err)
`endif
   );

   pipe_mux_stage #(
      .WIDTH  (32),
      .NUM_IN (3)
   ) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data3),
      .in_sel    (in_sel3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .flush     (flush3),
      .out_data  (out_data3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
`ifdef PIPE_MUX_SELCHK_EN
      ,
      .sel_err   (sel_err3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the next inputs already driven.
   task automatic cycle();
      logic acc;
      logic pop;
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      acc = in_valid && (q.size() < 2);
      pop = (q.size() != 0) && out_ready;
      if (pop) begin
         chk("out_data", out_data, q[0]);
         void'(q.pop_front());
      end
      if (flush) begin
         q.delete();
      end else if (acc) begin
         q.push_back(ops[in_sel]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid3 = 1'b1;
      in_sel3   = 2'd0;
      flush3    = 1'b0;
      out_ready3 = 1'b0;
      for (int k = 0; k < 4; k++) ops[k] = 32'h1111_1111 * (k + 1);
      for (int k = 0; k < 3; k++) ops3[k] = 32'hA5A5_0000 + k;

      // Reset held with in_valid asserted must capture nothing.
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_data", out_data, 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst3_out_valid", 32'(out_valid3), 32'd0);
         chk("rst3_in_ready", 32'(in_ready3), 32'd1);
`ifdef PIPE_MUX_SELCHK_EN
         chk("rst_sel_err", 32'(sel_err), 32'd0);
`endif
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_valid3 = 1'b0;
      cycle();
      cycle();

      // Select sweep, back-to-back.
      out_ready = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_valid = 1'b1;
         in_sel   = 2'(s);
         cycle();
      end
      in_valid = 1'b0;
      repeat (3) cycle();

      // Backpressure into FULL, then drain in order.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      ops[1]    = 32'hB000_0001;
      cycle();
      in_sel    = 2'd2;
      ops[2]    = 32'hB000_0002;
      cycle();
      in_sel    = 2'd3;
      ops[3]    = 32'hB000_0003;
      cycle();
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      // Flush while FULL with a beat offered in the same cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      ops[0]    = 32'hF000_0000;
      cycle();
      in_sel    = 2'd1;
      ops[1]    = 32'hF000_0001;
      cycle();
      flush     = 1'b1;
      in_sel    = 2'd2;
      ops[2]    = 32'hDEAD_BEEF;
      cycle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      repeat (3) cycle();

      // NUM_IN=3: in-range then out-of-range select.
      out_ready3 = 1'b1;
      in_valid3  = 1'b1;
      in_sel3    = 2'd2;
      @(posedge clk);
      #1;
      chk("n3_valid", 32'(out_valid3), 32'd1);
      chk("n3_sel2", out_data3, 32'hA5A5_0002);
      in_sel3    = 2'd3;
      @(posedge clk);
      #1;
      in_valid3  = 1'b0;
      chk("n3_valid_oor", 32'(out_valid3), 32'd1);
      chk("n3_sel3_zero", out_data3, 32'd0);
`ifdef PIPE_MUX_SELCHK_EN
      chk("sel_err_set", 32'(sel_err3), 32'd1);
      chk("sel_err_n4", 32'(sel_err), 32'd0);
`endif
      flush3 = 1'b1;
      @(posedge clk);
      #1;
      flush3 = 1'b0;
      chk("n3_flush_valid", 32'(out_valid3), 32'd0);
      chk("n3_flush_ready", 32'(in_ready3), 32'd1);
`ifdef PIPE_MUX_SELCHK_EN
      chk("sel_err_after_flush", 32'(sel_err3), 32'd1);
`endif
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("n3_rst_valid", 32'(out_valid3), 32'd0);
`ifdef PIPE_MUX_SELCHK_EN
      chk("sel_err_rst", 32'(sel_err3), 32'd0);
`endif
      q.delete();

      // Random traffic with occasional squash.
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         in_sel    = 2'($urandom_range(3));
         for (int k = 0; k < 4; k++) ops[k] = $urandom;
         out_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(31) == 0);
         cycle();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("drained_out_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
